pcm_to_i2s: RTL and testbench

//  Transmit side of our I2S link: takes parallel left/right PCM samples via a valid/ready handshake and

---
 rtl/i2s_pkg.sv | 18 +
 rtl/i2s_frame_timer.sv | 64 ++++++
 rtl/pcm_to_i2s.sv | 122 ++++++++++++
 tb/tb_pcm_to_i2s.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Definitions shared by the I2S transmit and receive paths.
package i2s_pkg;

    localparam int SAMPLE_BITS_DEF = 8;
    localparam int SLOT_BITS_DEF   = 16;

    function automatic int slot_idx_w(input int slot_bits);
        return (slot_bits > 1) ? $clog2(slot_bits) : 1;
    endfunction

    localparam int SLOT_IDX_W = slot_idx_w(SLOT_BITS_DEF);

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } ch_e;

endpackage

// File: rtl/i2s_frame_timer.sv
// I2S frame timing: slot index, word select, frame-start pulse and the
// end-of-frame load strobe. Bit clock is clk.
module i2s_frame_timer
    import i2s_pkg::*;
#(
    parameter int SLOT_BITS = SLOT_BITS_DEF,
    parameter int IDX_W     = slot_idx_w(SLOT_BITS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    output logic [IDX_W-1:0] slot_idx,
    output logic             ws,
    output logic             frame_start,
    output logic             load_now
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLOT_BITS - 1);

    logic [IDX_W-1:0] k_q, k_d;
    ch_e              ws_q, ws_d;
    logic             fs_q, fs_d;
    logic             en_q, en_d;
    logic             en_rise;
    logic             slot_end;

    always_comb begin
        en_rise  = enable & ~en_q;
        slot_end = (k_q == LAST_IDX);
        // A rising enable behaves like the end of a right slot so the first
        // enabled cycle is a fresh left slot carrying the held pair.
        load_now = enable & (en_rise | ((ws_q == CH_RIGHT) & slot_end));
        k_d      = k_q + IDX_W'(1);
        ws_d     = ws_q;
        if (!enable || en_rise) begin
            k_d  = '0;
            ws_d = CH_LEFT;
        end else if (slot_end) begin
            k_d  = '0;
            ws_d = (ws_q == CH_LEFT) ? CH_RIGHT : CH_LEFT;
        end
        fs_d = load_now;
        en_d = enable;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k_q  <= '0;
            ws_q <= CH_LEFT;
            fs_q <= 1'b0;
            en_q <= 1'b0;
        end else begin
            k_q  <= k_d;
            ws_q <= ws_d;
            fs_q <= fs_d;
            en_q <= en_d;
        end
    end

    assign slot_idx    = k_q;
    assign ws          = ws_q;
    assign frame_start = fs_q;

endmodule

// File: rtl/pcm_to_i2s.sv
// I2S transmitter: accepts left/right PCM pairs over valid/ready, holds one
// pair, and shifts it out MSB first with the one-bit I2S delay.
module pcm_to_i2s
    import i2s_pkg::*;
#(
    parameter int SAMPLE_BITS = SAMPLE_BITS_DEF,
    parameter int SLOT_BITS   = SLOT_BITS_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [SAMPLE_BITS-1:0] sample_left,
    input  logic [SAMPLE_BITS-1:0] sample_right,
    input  logic                   sample_valid,
    output logic                   sample_ready,
    output logic                   ws,
    output logic                   sdo,
    output logic                   frame_start,
    output logic                   underrun
);

    localparam int               IDX_W    = slot_idx_w(SLOT_BITS);
    localparam logic [IDX_W-1:0] DATA_END = IDX_W'(SAMPLE_BITS);

    generate
        if (SLOT_BITS < SAMPLE_BITS + 1) begin : g_bad_slot
            $error("pcm_to_i2s: SLOT_BITS must be at least SAMPLE_BITS+1");
        end
    endgenerate

    typedef struct packed {
        logic [SAMPLE_BITS-1:0] left;
        logic [SAMPLE_BITS-1:0] right;
    } pair_t;

    pair_t                  hold_q, hold_d;
    logic                   hold_full_q, hold_full_d;
    logic                   primed_q, primed_d;
    logic [SAMPLE_BITS-1:0] left_sh_q, left_sh_d;
    logic [SAMPLE_BITS-1:0] right_sh_q, right_sh_d;
    logic                   sdo_q, sdo_d;
    logic                   underrun_q, underrun_d;

    logic [IDX_W-1:0] slot_idx;
    logic             load_now;
    logic             accept;

    i2s_frame_timer #(
        .SLOT_BITS (SLOT_BITS),
        .IDX_W     (IDX_W)
    ) u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .slot_idx    (slot_idx),
        .ws          (ws),
        .frame_start (frame_start),
        .load_now    (load_now)
    );

    assign sample_ready = ~hold_full_q | load_now;

    always_comb begin
        accept      = sample_valid & sample_ready;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        primed_d    = primed_q | accept;
        left_sh_d   = left_sh_q;
        right_sh_d  = right_sh_q;
        sdo_d       = 1'b0;
        underrun_d  = 1'b0;
        if (load_now) begin
            if (hold_full_q) begin
                left_sh_d  = hold_q.left;
                right_sh_d = hold_q.right;
            end else begin
                left_sh_d  = '0;
                right_sh_d = '0;
                underrun_d = primed_q;
            end
            hold_full_d = 1'b0;
        end else if (enable && (slot_idx < DATA_END)) begin
            // sdo is registered, so the bit for index k+1 is launched at index k.
            if (ws == logic'(CH_RIGHT)) begin
                sdo_d      = right_sh_q[SAMPLE_BITS-1];
                right_sh_d = right_sh_q << 1;
            end else begin
                sdo_d     = left_sh_q[SAMPLE_BITS-1];
                left_sh_d = left_sh_q << 1;
            end
        end
        if (accept) begin
            hold_d.left  = sample_left;
            hold_d.right = sample_right;
            hold_full_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            primed_q    <= 1'b0;
            left_sh_q   <= '0;
            right_sh_q  <= '0;
            sdo_q       <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            primed_q    <= primed_d;
            left_sh_q   <= left_sh_d;
            right_sh_q  <= right_sh_d;
            sdo_q       <= sdo_d;
            underrun_q  <= underrun_d;
        end
    end

    assign sdo      = sdo_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_pcm_to_i2s.sv
// Directed bench for pcm_to_i2s (SAMPLE_BITS=8, SLOT_BITS=16): whole frames
// are captured and compared with hand-computed bit patterns.
module tb_pcm_to_i2s;

    logic       clk = 1'b0;
    logic       rst_n, enable, sample_valid, sample_ready;
    logic       ws, sdo, frame_start, underrun;
    logic [7:0] sample_left, sample_right;

    int checks = 0;
    int errors = 0;

    // Per-frame patterns: bit 31 is the first cycle of the frame.
    typedef struct {
        logic [7:0]  l;
        logic [7:0]  r;
        logic [15:0] el;
        logic [15:0] er;
    } vec_t;

    vec_t        vt [6];
    logic [31:0] burst_exp [4];
    logic [15:0] drv_q [$];
    logic        pop_pending = 1'b0;
    logic [31:0] r;

    always #5 clk = ~clk;

    pcm_to_i2s #(.SAMPLE_BITS(8), .SLOT_BITS(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .sample_left  (sample_left),
        .sample_right (sample_right),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .ws           (ws),
        .sdo          (sdo),
        .frame_start  (frame_start),
        .underrun     (underrun)
    );

    // Source: presents the queue head, holds it until accepted.
    initial begin
        sample_valid = 1'b0;
        sample_left  = '0;
        sample_right = '0;
        forever begin
            @(negedge clk);
            pop_pending = sample_valid && sample_ready && rst_n;
            @(posedge clk);
            #1;
            if (pop_pending && drv_q.size() > 0) void'(drv_q.pop_front());
            if (drv_q.size() > 0) begin
                sample_valid = 1'b1;
                {sample_left, sample_right} = drv_q[0];
            end else begin
                sample_valid = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cap_frame(output logic [31:0] ws_v, output logic [31:0] sdo_v,
                             output logic [31:0] fs_v, output logic [31:0] ur_v,
                             output logic [31:0] rdy_v);
        for (int p = 0; p < 32; p++) begin
            ws_v[31-p]  = ws;
            sdo_v[31-p] = sdo;
            fs_v[31-p]  = frame_start;
            ur_v[31-p]  = underrun;
            rdy_v[31-p] = sample_ready;
            step(1);
        end
    endtask

    task automatic frame(input string nm, input logic [31:0] exp_sdo, input logic exp_ur,
                         output logic [31:0] rdy_v);
        logic [31:0] w, s, f, u;
        cap_frame(w, s, f, u, rdy_v);
        chk({nm, " ws"}, w, 32'h0000FFFF);
        chk({nm, " frame_start"}, f, 32'h80000000);
        chk({nm, " sdo"}, s, exp_sdo);
        chk({nm, " underrun"}, u, exp_ur ? 32'h80000000 : 32'h0);
    endtask

    initial begin
        vt[0] = '{8'hA5, 8'h3C, 16'h5280, 16'h1E00};
        vt[1] = '{8'hFF, 8'h80, 16'h7F80, 16'h4000};
        vt[2] = '{8'h01, 8'h7F, 16'h0080, 16'h3F80};
        vt[3] = '{8'h00, 8'hFE, 16'h0000, 16'h7F00};
        vt[4] = '{8'h5A, 8'hC3, 16'h2D00, 16'h6180};
        vt[5] = '{8'h80, 8'h01, 16'h4000, 16'h0080};
        burst_exp = '{32'h08000880, 32'h09000980, 32'h0A000A80, 32'h0B000B80};

        rst_n  = 1'b0;
        enable = 1'b1;
        step(3);
        chk("reset outputs", {28'b0, ws, sdo, frame_start, underrun}, 32'h0);
        chk("reset ready", {31'b0, sample_ready}, 32'h1);
        rst_n = 1'b1;
        step(1);

        frame("idle0", 32'h0, 1'b0, r);
        frame("idle1", 32'h0, 1'b0, r);

        // Each pair is offered at the start of a frame and must appear in the next one.
        for (int i = 0; i <= 6; i++) begin
            if (i < 6) drv_q.push_back({vt[i].l, vt[i].r});
            if (i == 0) frame("idle2", 32'h0, 1'b0, r);
            else frame($sformatf("vec%0d", i - 1), {vt[i-1].el, vt[i-1].er}, 1'b0, r);
        end

        frame("underrun0", 32'h0, 1'b1, r);

        // Back-to-back pairs: later ones are taken on the load_now cycle with hold full.
        for (int k = 0; k < 4; k++) drv_q.push_back({8'h10 + 8'(2*k), 8'h11 + 8'(2*k)});
        frame("underrun1", 32'h0, 1'b1, r);
        chk("burst hold-off ready", r & 32'h0000FFFF, 32'h00000001);
        for (int k = 0; k < 4; k++) begin
            frame($sformatf("burst%0d", k), burst_exp[k], 1'b0, r);
            chk($sformatf("burst%0d ready", k), r, (k < 3) ? 32'h00000001 : 32'hFFFFFFFF);
        end
        chk("burst drained", drv_q.size(), 32'h0);

        // Reset in the middle of a left slot with a pair pending.
        drv_q.push_back(16'hF00F);
        frame("underrun2", 32'h0, 1'b1, r);
        drv_q.push_back(16'h7788);
        step(3);
        chk("mid-left sdo", {31'b0, sdo}, 32'h1);
        chk("mid-left ready", {31'b0, sample_ready}, 32'h0);
        rst_n = 1'b0;
        step(1);
        chk("mid reset outputs", {28'b0, ws, sdo, frame_start, underrun}, 32'h0);
        chk("mid reset ready", {31'b0, sample_ready}, 32'h1);
        rst_n = 1'b1;
        step(1);
        frame("post_rst0", 32'h0, 1'b0, r);
        frame("post_rst1", 32'h0, 1'b0, r);

        // Disabled: outputs idle, one pair still accepted and loaded on enable rise.
        enable = 1'b0;
        step(3);
        chk("disabled outputs", {28'b0, ws, sdo, frame_start, underrun}, 32'h0);
        drv_q.push_back(16'hAA55);
        step(3);
        chk("disabled hold ready", {31'b0, sample_ready}, 32'h0);
        chk("disabled drained", drv_q.size(), 32'h0);
        enable = 1'b1;
        step(1);
        frame("en_rise", 32'h55002A80, 1'b0, r);
        frame("en_underrun", 32'h0, 1'b1, r);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
